// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers
// the in-order responses in a small queue and hands {inst, inst_pc} to
// decode. Redirects flush the queue and mark every in-flight read as stale.
// A misaligned redirect target produces a single fault marker, after which
// fetch idles until the next redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  // Queue pointer width and counter width (counters must hold QUEUE_DEPTH).
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  // Requests in flight plus queued words may never exceed the queue size,
  // so every response that is kept always finds a free slot.
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(QUEUE_DEPTH);

  // Instruction handed to decode alongside a misaligned-target fault (addi x0,x0,0).
  localparam logic [31:0] FAULT_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [31:0]     fetch_pc;
  logic [31:0]     rsp_pc;
  logic [31:0]     fault_pc;

  logic [31:0]     q_inst [QUEUE_DEPTH];
  logic [31:0]     q_pc   [QUEUE_DEPTH];
  logic [PW-1:0]   q_head;
  logic [PW-1:0]   q_tail;
  logic [CW-1:0]   q_count;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_nxt;
  logic [CW:0]     credit_used;

  logic            redirect_misaligned;
  logic            req_fire;
  logic            rsp_fire;
  logic            drop_rsp;
  logic            push;
  logic            pop;

  assign imem_req_addr       = fetch_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Handshake and queue bookkeeping for this cycle.
  always_comb begin
    credit_used = {1'b0, q_count} + {1'b0, outstanding};
    req_fire    = imem_req_valid && imem_req_ready;
    rsp_fire    = imem_rsp_valid;
    // A stale response is consumed against drop_cnt; a live one is queued
    // unless a redirect discards it in the same cycle.
    drop_rsp    = rsp_fire && (drop_cnt != '0);
    push        = rsp_fire && (drop_cnt == '0) && !redirect_valid && !rst;
    // A redirect flushes the queue, so a concurrent pop has no effect.
    pop         = inst_valid && inst_ready && (state == RUN) && !redirect_valid;
    out_nxt     = outstanding + CW'(req_fire) - CW'(rsp_fire);
  end

  // Next state and all decode/memory-facing outputs.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    inst           = '0;
    inst_pc        = '0;
    inst_fault     = 1'b0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          imem_req_valid = (credit_used < CREDIT_MAX);
          if (q_count != '0) begin
            inst_valid = 1'b1;
            inst       = q_inst[q_head];
            inst_pc    = q_pc[q_head];
          end
        end
        FAULT: begin
          inst_valid = 1'b1;
          inst       = FAULT_INST;
          inst_pc    = fault_pc;
          inst_fault = 1'b1;
          if (inst_ready) begin
            state_nxt = HALT;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase

      // Redirect wins over everything, in every state.
      if (redirect_valid) begin
        state_nxt = redirect_misaligned ? FAULT : RUN;
      end
    end
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so all
  // flops update together from the values sampled at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // PCs, queue pointers and in-flight counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      fault_pc    <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle's accounting,
        // including a request accepted this very cycle, is wrong-path.
        drop_cnt <= out_nxt;
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        fault_pc <= redirect_pc;
        q_head   <= '0;
        q_tail   <= '0;
        q_count  <= '0;
      end else begin
        if (drop_rsp) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          q_tail <= q_tail + PW'(1);
        end
        if (pop) begin
          q_head <= q_head + PW'(1);
        end
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage, written at the tail on every kept response.
  // NOTE: the storage array has no reset; q_count gates every read, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[q_tail] <= imem_rsp_data;
      q_pc[q_tail]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a constant-latency in-order
// memory model returning addr ^ 32'hA5A5_0000, directed sequences for the
// cycle-exact cases and a table of redirect targets.
module tb_inst_fetch_unit;

  localparam logic [31:0] DATA_KEY    = 32'hA5A5_0000;
  localparam int          QUEUE_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;
  bit hold_req = 1'b0;

  inst_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Memory model: constant latency, in order, shares rst with the DUT.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mem_req_t;

  mem_req_t    pend[$];
  logic [31:0] edge_cnt = 32'd0;
  int          mem_lat  = 1;

  always @(posedge clk) begin
    logic        hs;
    logic [31:0] a;
    logic        pres;
    logic        r;
    hs   = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    pres = imem_rsp_valid;
    r    = rst;
    edge_cnt = edge_cnt + 32'd1;
    #1;
    if (r) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (pres && pend.size() > 0) void'(pend.pop_front());
      if (hs) pend.push_back('{addr: a, due: edge_cnt + 32'(mem_lat)});
      if (pend.size() > 0 && pend[0].due <= edge_cnt + 32'd1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].addr ^ DATA_KEY;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Continuous monitors: no wrong-path data, request held until accepted,
  // queue never written while full.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (inst_valid && !inst_fault) check("inst_matches_pc", inst, inst_pc ^ DATA_KEY);
      if (hold_req) check("req_held", 32'(imem_req_valid), 32'd1);
      check("no_push_when_full", 32'(dut.push && (32'(dut.q_count) == QUEUE_DEPTH)), 32'd0);
    end
    hold_req = !rst && imem_req_valid && !imem_req_ready && !redirect_valid;
  end

  // ---------------------------------------------------------------------
  // Cycle helpers: inputs change 1 time unit after posedge, outputs are
  // sampled at negedge.
  // ---------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid),     32'd0);
    check({tag, "_inst"},       inst,                32'd0);
    check({tag, "_inst_pc"},    inst_pc,             32'd0);
    check({tag, "_inst_fault"}, 32'(inst_fault),     32'd0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    sample();
    check_quiet_outputs("reset");
    next_cycle();
    rst     = 1'b0;
    started = 1'b1;
  endtask

  // Waits (bounded) for inst_valid, starting in the current cycle.
  task automatic wait_inst(input int bound, output int found_at);
    found_at = -1;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (inst_valid) begin
        found_at = i;
        break;
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------
  // Redirect vector table.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic        fault;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } redir_vec_t;

  redir_vec_t vecs[6];

  initial begin
    int          found_at;
    int          n_pops;
    logic [31:0] exp_pc;
    logic [31:0] hs_addr[$];

    vecs[0] = '{pc: 32'h0000_0102, lat: 1, fault: 1'b1, exp_inst: 32'h0000_0013, exp_pc: 32'h0000_0102};
    vecs[1] = '{pc: 32'h0000_0200, lat: 1, fault: 1'b0, exp_inst: 32'hA5A5_0200, exp_pc: 32'h0000_0200};
    vecs[2] = '{pc: 32'h0000_0FFD, lat: 2, fault: 1'b1, exp_inst: 32'h0000_0013, exp_pc: 32'h0000_0FFD};
    vecs[3] = '{pc: 32'hFFFF_FFFC, lat: 2, fault: 1'b0, exp_inst: 32'h5A5A_FFFC, exp_pc: 32'hFFFF_FFFC};
    vecs[4] = '{pc: 32'h0000_0003, lat: 1, fault: 1'b1, exp_inst: 32'h0000_0013, exp_pc: 32'h0000_0003};
    vecs[5] = '{pc: 32'h0000_1000, lat: 1, fault: 1'b0, exp_inst: 32'hA5A5_1000, exp_pc: 32'h0000_1000};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    next_cycle();

    // --- 1: streaming fetch, 1-cycle memory -----------------------------
    mem_lat    = 1;
    inst_ready = 1'b1;
    do_reset();
    sample();
    check("t1_c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_c0_req_addr",  imem_req_addr,       32'h0000_0000);
    check("t1_c0_inst_valid", 32'(inst_valid),    32'd0);
    next_cycle();
    sample();
    check("t1_c1_req_addr",  imem_req_addr,       32'h0000_0004);
    check("t1_c1_inst_valid", 32'(inst_valid),    32'd0);
    next_cycle();
    sample();
    check("t1_c2_inst_valid", 32'(inst_valid),    32'd1);
    check("t1_c2_inst_pc",   inst_pc,             32'h0000_0000);
    check("t1_c2_inst",      inst,                32'hA5A5_0000);
    check("t1_c2_req_valid", 32'(imem_req_valid), 32'd0);
    next_cycle();
    exp_pc = 32'h0000_0004;
    n_pops = 0;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = !(i >= 10 && i <= 13);
      inst_ready     = (i % 5 != 3);
      sample();
      if (inst_valid && inst_ready) begin
        check("t1_stream_pc", inst_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
      next_cycle();
    end
    imem_req_ready = 1'b1;
    check("t1_progress", 32'(n_pops >= 8), 32'd1);

    // --- 2: decode stalled, credit limit ---------------------------------
    inst_ready = 1'b0;
    do_reset();
    hs_addr.delete();
    for (int i = 0; i < 8; i++) begin
      sample();
      if (imem_req_valid && imem_req_ready) hs_addr.push_back(imem_req_addr);
      next_cycle();
    end
    check("t2_hs_count", 32'(hs_addr.size()), 32'd2);
    if (hs_addr.size() >= 2) begin
      check("t2_hs0_addr", hs_addr[0], 32'h0000_0000);
      check("t2_hs1_addr", hs_addr[1], 32'h0000_0004);
    end
    inst_ready = 1'b1;
    sample();
    check("t2_req_idle",   32'(imem_req_valid), 32'd0);
    check("t2_head_pc",    inst_pc,             32'h0000_0000);
    next_cycle();
    inst_ready = 1'b0;
    sample();
    check("t2_after_pop_pc",    inst_pc,             32'h0000_0004);
    check("t2_new_req_valid",   32'(imem_req_valid), 32'd1);
    check("t2_new_req_addr",    imem_req_addr,       32'h0000_0008);
    next_cycle();
    sample();
    check("t2_one_pop_pc",      inst_pc,             32'h0000_0004);
    check("t2_req_idle_again",  32'(imem_req_valid), 32'd0);
    next_cycle();

    // --- 3: redirect with two requests in flight, 3-cycle memory ---------
    mem_lat    = 3;
    inst_ready = 1'b1;
    do_reset();
    sample();
    check("t3_req0_addr", imem_req_addr, 32'h0000_0000);
    next_cycle();
    sample();
    check("t3_req1_addr", imem_req_addr, 32'h0000_0004);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    sample();
    check("t3_credit_full", 32'(imem_req_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    wait_inst(20, found_at);
    check("t3_latency",  32'(found_at), 32'd5);
    check("t3_first_pc", inst_pc,       32'h0000_0100);
    check("t3_first_inst", inst,        32'hA5A5_0100);
    next_cycle();

    // --- 4: redirect table (aligned targets and misaligned faults) -------
    for (int v = 0; v < 6; v++) begin
      mem_lat        = vecs[v].lat;
      inst_ready     = !vecs[v].fault;
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].pc;
      sample();
      next_cycle();
      redirect_valid = 1'b0;
      wait_inst(30, found_at);
      check($sformatf("vec%0d_found", v), 32'(found_at >= 0), 32'd1);
      check($sformatf("vec%0d_pc", v),    inst_pc,            vecs[v].exp_pc);
      check($sformatf("vec%0d_inst", v),  inst,               vecs[v].exp_inst);
      check($sformatf("vec%0d_fault", v), 32'(inst_fault),    32'(vecs[v].fault));
      if (vecs[v].fault) begin
        check($sformatf("vec%0d_fault_now", v), 32'(found_at), 32'd0);
        check($sformatf("vec%0d_no_req", v), 32'(imem_req_valid), 32'd0);
        next_cycle();
        sample();
        check($sformatf("vec%0d_held_valid", v), 32'(inst_valid), 32'd1);
        check($sformatf("vec%0d_held_pc", v),    inst_pc,         vecs[v].exp_pc);
        check($sformatf("vec%0d_held_fault", v), 32'(inst_fault), 32'd1);
        next_cycle();
        inst_ready = 1'b1;
        sample();
        check($sformatf("vec%0d_accept_valid", v), 32'(inst_valid), 32'd1);
        next_cycle();
        sample();
        check($sformatf("vec%0d_halt_valid", v), 32'(inst_valid),     32'd0);
        check($sformatf("vec%0d_halt_req", v),   32'(imem_req_valid), 32'd0);
      end
      next_cycle();
    end

    // --- 5: redirect colliding with response, pop and handshake ----------
    mem_lat    = 1;
    inst_ready = 1'b1;
    found_at   = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (imem_req_valid && imem_req_ready && imem_rsp_valid && inst_ready) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        found_at       = i;
        break;
      end
    end
    check("t5_collision_found", 32'(found_at >= 0), 32'd1);
    if (found_at >= 0) begin
      sample();
      check("t5_setup", {29'd0, imem_req_valid, imem_rsp_valid, redirect_valid}, 32'd7);
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      check("t5_queue_empty",  32'(inst_valid),     32'd0);
      check("t5_req_valid",    32'(imem_req_valid), 32'd1);
      check("t5_req_addr",     imem_req_addr,       32'h0000_0040);
      next_cycle();
      wait_inst(20, found_at);
      check("t5_latency",  32'(found_at), 32'd1);
      check("t5_first_pc", inst_pc,       32'h0000_0040);
    end
    next_cycle();

    // --- 6: reset mid-operation ------------------------------------------
    mem_lat    = 3;
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) next_cycle();
    check("t6_setup_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    sample();
    check_quiet_outputs("t6_rst");
    next_cycle();
    rst = 1'b0;
    sample();
    check("t6_inst_valid", 32'(inst_valid),     32'd0);
    check("t6_req_valid",  32'(imem_req_valid), 32'd1);
    check("t6_req_addr",   imem_req_addr,       32'h0000_0000);
    next_cycle();
    inst_ready = 1'b1;
    wait_inst(20, found_at);
    check("t6_found",    32'(found_at >= 0), 32'd1);
    check("t6_first_pc", inst_pc,            32'h0000_0000);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
